// File: rtl/random_range_if.sv
// ---------------------------------------------------------------------------
// random_range_if
// Request/response bundle for random_range_gen.
//   enable     : requester -> generator, LFSR advances while high
//   trigger    : requester -> generator, rising edge requests one sample
//   force_en   : requester -> generator, override output with a fixed value
//   dout       : generator -> requester, result value (SIZE_BITS wide)
//   dout_valid : generator -> requester, one-cycle pulse when dout updates
//   busy       : generator -> requester, high while a reduction is running
// ---------------------------------------------------------------------------
interface random_range_if #(
  parameter int SIZE_BITS = 4
);
  logic                 enable;
  logic                 trigger;
  logic                 force_en;
  logic [SIZE_BITS-1:0] dout;
  logic                 dout_valid;
  logic                 busy;

  modport master (
    output enable, trigger, force_en,
    input  dout, dout_valid, busy
  );

  modport slave (
    input  enable, trigger, force_en,
    output dout, dout_valid, busy
  );
endinterface

// File: rtl/random_range_gen.sv
// ---------------------------------------------------------------------------
// random_range_gen
// Pseudo-random value generator. A free-running Galois LFSR is sampled on the
// rising edge of trigger; the sample is reduced modulo RANGE
// (MAX_VAL-MIN_VAL+1) by a bit-serial restoring remainder engine, one sample
// bit per clock MSB first, and offset by MIN_VAL. force_en overrides the
// output with FORCE_VAL and aborts any reduction in progress.
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : random_range_if.slave (enable, trigger, force_en in;
//            dout, dout_valid, busy out)
// ---------------------------------------------------------------------------
module random_range_gen #(
  parameter int SIZE_BITS = 4,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 6,
  parameter int FORCE_VAL = 7,
  parameter int LFSR_BITS = 16,
  parameter logic [LFSR_BITS-1:0] TAPS = 16'hB400,
  parameter logic [LFSR_BITS-1:0] SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          resetN,
  random_range_if.slave bus
);

  // Remainder needs one extra bit so the shifted partial value never wraps.
  localparam int REM_W = SIZE_BITS + 1;
  localparam int CNT_W = (LFSR_BITS > 1) ? $clog2(LFSR_BITS) : 1;
  localparam logic [REM_W-1:0]     RANGE_C = REM_W'(MAX_VAL - MIN_VAL + 1);
  localparam logic [LFSR_BITS-1:0] SEED_C  = (SEED == '0) ? LFSR_BITS'(1) : SEED;
  localparam logic [SIZE_BITS-1:0] MIN_C   = SIZE_BITS'(MIN_VAL);
  localparam logic [SIZE_BITS-1:0] FORCE_C = SIZE_BITS'(FORCE_VAL);

  typedef enum logic {IDLE, REDUCE} state_t;

  // One restoring-division step: shift in the next dividend bit, subtract the
  // divisor if it fits.
  function automatic logic [REM_W-1:0] rem_step(input logic [REM_W-1:0] rem,
                                                input logic              b);
    logic [REM_W-1:0] t;
    t = (rem << 1) | REM_W'(b);
    return (t >= RANGE_C) ? (t - RANGE_C) : t;
  endfunction

  state_t               state_q, state_d;
  logic [LFSR_BITS-1:0] lfsr_q, lfsr_d;
  logic                 trig_dly_q, trig_dly_d;
  logic                 force_dly_q, force_dly_d;
  logic [SIZE_BITS-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 busy_q, busy_d;
  logic [LFSR_BITS-1:0] sample_q, sample_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [REM_W-1:0]     rem_next;
  logic                 trig_edge;

  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.enable) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end

    trig_dly_d   = bus.trigger;
    force_dly_d  = bus.force_en;
    trig_edge    = bus.trigger & ~trig_dly_q;

    state_d      = state_q;
    busy_d       = busy_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sample_d     = sample_q;
    rem_d        = rem_q;
    bitcnt_d     = bitcnt_q;
    rem_next     = rem_step(rem_q, sample_q[bitcnt_q]);

    if (bus.force_en) begin
      // Override wins over everything; only its rising edge is announced.
      state_d      = IDLE;
      busy_d       = 1'b0;
      dout_d       = FORCE_C;
      dout_valid_d = ~force_dly_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_edge) begin
            sample_d = lfsr_q;
            rem_d    = '0;
            bitcnt_d = CNT_W'(LFSR_BITS - 1);
            state_d  = REDUCE;
            busy_d   = 1'b1;
          end
        end
        REDUCE: begin
          rem_d    = rem_next;
          bitcnt_d = bitcnt_q - CNT_W'(1);
          if (bitcnt_q == '0) begin
            dout_d       = rem_next[SIZE_BITS-1:0] + MIN_C;
            dout_valid_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED_C;
      trig_dly_q   <= 1'b0;
      force_dly_q  <= 1'b0;
      dout_q       <= MIN_C;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      trig_dly_q   <= trig_dly_d;
      force_dly_q  <= force_dly_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Reduction datapath is always (re)loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    sample_q <= sample_d;
    rem_q    <= rem_d;
    bitcnt_q <= bitcnt_d;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_random_range_gen.sv
// ---------------------------------------------------------------------------
// tb_random_range_gen
// Three generator instances (ranges 0..6, 2..9, 5..5) share one stimulus.
// Stimulus pushes expected results (value and arrival cycle) into per-instance
// queues; a negedge monitor pops and compares on every dout_valid pulse.
// ---------------------------------------------------------------------------
module tb_random_range_gen;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic enable = 1'b0, trigger = 1'b0, force_en = 1'b0;
  always #5 clk = ~clk;

  random_range_if #(.SIZE_BITS(4)) if_a ();
  random_range_if #(.SIZE_BITS(4)) if_b ();
  random_range_if #(.SIZE_BITS(4)) if_c ();

  assign if_a.enable = enable;  assign if_a.trigger = trigger;  assign if_a.force_en = force_en;
  assign if_b.enable = enable;  assign if_b.trigger = trigger;  assign if_b.force_en = force_en;
  assign if_c.enable = enable;  assign if_c.trigger = trigger;  assign if_c.force_en = force_en;

  random_range_gen #(.SIZE_BITS(4), .MIN_VAL(0), .MAX_VAL(6), .FORCE_VAL(7), .LFSR_BITS(16),
                     .TAPS(16'hB400), .SEED(16'hACE1))
    dut_a (.clk(clk), .resetN(resetN), .bus(if_a.slave));
  random_range_gen #(.SIZE_BITS(4), .MIN_VAL(2), .MAX_VAL(9), .FORCE_VAL(7), .LFSR_BITS(16),
                     .TAPS(16'hB400), .SEED(16'hACE1))
    dut_b (.clk(clk), .resetN(resetN), .bus(if_b.slave));
  random_range_gen #(.SIZE_BITS(4), .MIN_VAL(5), .MAX_VAL(5), .FORCE_VAL(7), .LFSR_BITS(16),
                     .TAPS(16'hB400), .SEED(16'hACE1))
    dut_c (.clk(clk), .resetN(resetN), .bus(if_c.slave));

  typedef struct {
    logic [3:0] val;
    int         due;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR used only to know which sample a trigger will capture.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge resetN) begin
    if (!resetN)     m_lfsr <= 16'hACE1;
    else if (enable) m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic cmp(input string tag, input logic [3:0] d, input exp_t e,
                     input int lo, input int hi);
    check({"value_", tag}, d, e.val);
    check({"latency_", tag}, cyc, e.due);
    check({"in_range_", tag}, int'(d >= 4'(lo) && d <= 4'(hi)), 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetN) begin
      if (if_a.dout_valid) begin
        if (qa.size() == 0) check("unexpected_valid_a", 1, 0);
        else begin e = qa.pop_front(); cmp("a", if_a.dout, e, 0, 7); end
      end
      if (if_b.dout_valid) begin
        if (qb.size() == 0) check("unexpected_valid_b", 1, 0);
        else begin e = qb.pop_front(); cmp("b", if_b.dout, e, 2, 9); end
      end
      if (if_c.dout_valid) begin
        if (qc.size() == 0) check("unexpected_valid_c", 1, 0);
        else begin e = qc.pop_front(); cmp("c", if_c.dout, e, 5, 7); end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] mexp(input logic [15:0] s, input int lo, input int hi);
    int r;
    r = int'(s) % (hi - lo + 1) + lo;
    return r[3:0];
  endfunction

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input int due);
    qa.push_back('{a, due});
    qb.push_back('{b, due});
    qc.push_back('{c, due});
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qc.delete();
  endtask

  // Called at a negedge: the edge is captured at the next posedge and the
  // result is seen 16 edges later.
  task automatic trig_const(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    push(a, b, c, cyc + 17);
    trigger = 1'b1; tick(1); trigger = 1'b0;
  endtask

  task automatic trig_model();
    push(mexp(m_lfsr, 0, 6), mexp(m_lfsr, 2, 9), mexp(m_lfsr, 5, 5), cyc + 17);
    trigger = 1'b1; tick(1); trigger = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_pending", qa.size() + qb.size() + qc.size(), 0);
    clear_q();
  endtask

  initial begin
    #1 resetN = 1'b0;
    tick(2);
    check("rst_dout_a", if_a.dout, 0);
    check("rst_dout_b", if_b.dout, 2);
    check("rst_dout_c", if_c.dout, 5);
    check("rst_valid", if_a.dout_valid, 0);
    check("rst_busy", if_a.busy, 0);
    resetN = 1'b1;
    tick(2);

    // Seed sample: 44257 mod 7 = 3; mod 8 = 1 (+2); range of one gives 5.
    trig_const(4'd3, 4'd3, 4'd5);
    for (int i = 0; i < 16; i++) begin
      check("busy_during", if_a.busy, 1);
      tick(1);
    end
    check("busy_after", if_a.busy, 0);
    drain(40);

    // One LFSR step gives 0xE270 = 57968: mod 7 = 1, mod 8 = 0 (+2).
    enable = 1'b1; tick(1); enable = 1'b0;
    trig_const(4'd1, 4'd2, 4'd5);
    drain(40);

    // Held trigger yields one sample; a new edge while busy is ignored.
    push(mexp(m_lfsr, 0, 6), mexp(m_lfsr, 2, 9), mexp(m_lfsr, 5, 5), cyc + 17);
    trigger = 1'b1; tick(5);
    trigger = 1'b0; tick(1);
    trigger = 1'b1; tick(2);
    trigger = 1'b0;
    check("busy_while_retrig", if_a.busy, 1);
    drain(40);
    check("busy_end_retrig", if_a.busy, 0);
    tick(20);

    // Force mid-reduction aborts it and pulses once.
    trigger = 1'b1; tick(1); trigger = 1'b0; tick(7);
    clear_q();
    force_en = 1'b1;
    push(4'd7, 4'd7, 4'd7, cyc + 1);
    tick(1);
    check("force_busy", if_a.busy, 0);
    check("force_dout_a", if_a.dout, 7);
    check("force_dout_c", if_c.dout, 7);
    tick(3);
    trigger = 1'b1; tick(1); trigger = 1'b0;
    tick(20);
    check("forced_busy", if_b.busy, 0);
    check("forced_dout_b", if_b.dout, 7);
    force_en = 1'b0;
    tick(3);
    check("released_dout_a", if_a.dout, 7);
    trig_model();
    drain(40);

    // Reset mid-reduction: no pulse, outputs to MIN, LFSR back to the seed.
    trigger = 1'b1; tick(1); trigger = 1'b0; tick(9);
    clear_q();
    resetN = 1'b0;
    #1;
    check("midrst_dout_a", if_a.dout, 0);
    check("midrst_dout_b", if_b.dout, 2);
    check("midrst_busy", if_a.busy, 0);
    check("midrst_valid", if_a.dout_valid, 0);
    tick(2);
    resetN = 1'b1;
    tick(2);
    trig_const(4'd3, 4'd3, 4'd5);
    drain(40);

    // Free-running LFSR, back-to-back samples.
    enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      trig_model();
      tick(16 + $urandom_range(0, 3));
    end
    enable = 1'b0;
    drain(40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
